// File: rtl/seq_divider.sv
// seq_divider: restoring sequential divider, one quotient bit per clock.
// Ports: clk, reset (sync, active-high), start, dividend, divisor in;
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero out.
// Optional macro SEQ_DIVIDER_SIGNED_EN selects two's-complement operands.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a, b, r, q, a_ld, b_ld, r_n, q_n, q_f, r_f;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] diff;
  // Partial remainder stays below the divisor, so a WIDTH+1-bit difference
  // is enough for its MSB to act as the borrow.
  assign diff = {r, a[WIDTH-1]} - {1'b0, b};
  assign r_n = diff[WIDTH] ? {r[WIDTH-2:0], a[WIDTH-1]} : diff[WIDTH-1:0];
  assign q_n = {q[WIDTH-2:0], ~diff[WIDTH]};
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sa, sb;
  assign a_ld = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_ld = divisor[WIDTH-1] ? -divisor : divisor;
  // Divide-by-zero must report all ones regardless of the dividend sign.
  assign q_f = (b == '0) ? '1 : (sa ^ sb) ? -q_n : q_n;
  assign r_f = sa ? -r_n : r_n;
`else
  assign a_ld = dividend;
  assign b_ld = divisor;
  assign q_f = q_n;
  assign r_f = r_n;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      cnt <= '0;
      a <= '0;
      b <= '0;
      r <= '0;
      q <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa <= 1'b0;
      sb <= 1'b0;
`endif
    end else begin
      case (state)
        // A start held through DONE is taken on the DONE edge so back-to-back
        // operations see no idle gap.
        IDLE, DONE: begin
          done <= 1'b0;
          state <= IDLE;
          if (start) begin
            a <= a_ld;
            b <= b_ld;
            r <= '0;
            q <= '0;
            cnt <= CW'(WIDTH);
            busy <= 1'b1;
            div_by_zero <= 1'b0;
            state <= RUN;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sa <= dividend[WIDTH-1];
            sb <= divisor[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a <= a << 1;
          r <= r_n;
          q <= q_n;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            busy <= 1'b0;
            done <= 1'b1;
            quotient <= q_f;
            remainder <= r_f;
            div_by_zero <= (b == '0);
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (WIDTH=8).
module tb_seq_divider;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic busy, done, div_by_zero;
  logic [7:0] quotient, remainder;
  int tests = 0;
  int fails = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dd, dv, q, r;
    logic z;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic z);
`ifdef SEQ_DIVIDER_SIGNED_EN
    int x, y;
    x = $signed(a);
    y = $signed(b);
    z = (b == 0);
    q = z ? 8'hFF : 8'(x / y);
    r = z ? a : 8'(x % y);
`else
    z = (b == 0);
    q = z ? 8'hFF : a / b;
    r = z ? a : a % b;
`endif
  endtask

  task automatic launch(input logic [7:0] dd, input logic [7:0] dv);
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in the first cycle after the accepting edge; returns in the done cycle.
  task automatic wait_done(output int lat, output int bc, output logic [7:0] qm);
    lat = 1;
    bc = 0;
    qm = quotient;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t tbl[8];
  int lat, bc, lat2;
  logic [7:0] qm, eq, er, prev_q;
  logic ez;

  initial begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    tbl[0] = '{8'd100, 8'd7, 8'd14, 8'd2, 1'b0};
    tbl[1] = '{8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0};
    tbl[2] = '{8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0};
    tbl[3] = '{8'd5, 8'd0, 8'hFF, 8'd5, 1'b1};
    tbl[4] = '{8'd9, 8'd3, 8'd3, 8'd0, 1'b0};
    tbl[5] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0};
    tbl[6] = '{8'd0, 8'd5, 8'd0, 8'd0, 1'b0};
    tbl[7] = '{8'hF7, 8'd0, 8'hFF, 8'hF7, 1'b1};
`else
    tbl[0] = '{8'd100, 8'd7, 8'd14, 8'd2, 1'b0};
    tbl[1] = '{8'd255, 8'd1, 8'd255, 8'd0, 1'b0};
    tbl[2] = '{8'd3, 8'd200, 8'd0, 8'd3, 1'b0};
    tbl[3] = '{8'd5, 8'd0, 8'hFF, 8'd5, 1'b1};
    tbl[4] = '{8'd9, 8'd3, 8'd3, 8'd0, 1'b0};
    tbl[5] = '{8'd254, 8'd16, 8'd15, 8'd14, 1'b0};
    tbl[6] = '{8'd0, 8'd0, 8'hFF, 8'd0, 1'b1};
    tbl[7] = '{8'd128, 8'd3, 8'd42, 8'd2, 1'b0};
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      launch(tbl[i].dd, tbl[i].dv);
      check($sformatf("tbl%0d_dbz_clr", i), div_by_zero, 0);
      wait_done(lat, bc, qm);
      check($sformatf("tbl%0d_lat", i), lat, 9);
      check($sformatf("tbl%0d_busy", i), bc, 8);
      check($sformatf("tbl%0d_q", i), quotient, tbl[i].q);
      check($sformatf("tbl%0d_r", i), remainder, tbl[i].r);
      check($sformatf("tbl%0d_z", i), div_by_zero, tbl[i].z);
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("hold_q", quotient, tbl[7].q);

    // Back-to-back with start held high: 255/1 then 3/200.
    start = 1'b1;
    dividend = 8'd255;
    divisor = 8'd1;
    @(posedge clk);
    @(negedge clk);
    dividend = 8'd3;
    divisor = 8'd200;
    wait_done(lat, bc, qm);
    check("b2b_lat1", lat, 9);
    check("b2b_q1", quotient, 8'd255);
    check("b2b_r1", remainder, 8'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat2, bc, qm);
    check("b2b_gap", lat2, 9);
    check("b2b_q2", quotient, 8'd0);
    check("b2b_r2", remainder, 8'd3);
    @(negedge clk);

    // Start pulse and operand changes during RUN are ignored.
    launch(8'd100, 8'd7);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd50;
    divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    dividend = 8'd77;
    divisor = 8'd3;
    check("mid_hold_q", quotient, 8'd0);
    wait_done(lat, bc, qm);
    check("ign_lat", lat + 3, 9);
    check("ign_q", quotient, 8'd14);
    check("ign_r", remainder, 8'd2);
    bc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) bc++;
    end
    check("ign_no_extra_done", bc, 0);

    // Reset mid-RUN aborts, with reset winning over a simultaneous start.
    launch(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    bc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) bc++;
    end
    check("abort_quiet", bc, 0);
    launch(8'd9, 8'd3);
    wait_done(lat, bc, qm);
    check("post_rst_lat", lat, 9);
    check("post_rst_q", quotient, 8'd3);
    check("post_rst_r", remainder, 8'd0);

    // Randomized operands against the arithmetic model.
    prev_q = 8'd3;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      model(a, b, eq, er, ez);
      launch(a, b);
      wait_done(lat, bc, qm);
      check($sformatf("rnd%0d_hold", i), qm, prev_q);
      check($sformatf("rnd%0d_lat", i), lat, 9);
      check($sformatf("rnd%0d_q %0h/%0h", i, a, b), quotient, eq);
      check($sformatf("rnd%0d_r %0h/%0h", i, a, b), remainder, er);
      check($sformatf("rnd%0d_z", i), div_by_zero, ez);
      prev_q = eq;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
